// File: rtl/edac_4bit_pkg.sv
// edac_4bit_pkg: shared widths, codeword field offsets and encoder FSM states
package edac_4bit_pkg;
  localparam int DATA_W = 4;
  localparam int CRC_W = 4;
  localparam int CW_W = 16;
  localparam int DATA_LSB = 8;
  localparam int CRC_LSB = 0;
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} enc_state_e;
  function automatic logic [CW_W-1:0] pack_cw(input logic [DATA_W-1:0] d, input logic [CRC_W-1:0] r);
    logic [CW_W-1:0] cw;
    cw = '0;
    cw[DATA_LSB +: DATA_W] = d;
    cw[CRC_LSB +: CRC_W] = r;
    return cw;
  endfunction
endpackage

// File: rtl/edac_4bit_encoder_if.sv
// edac_4bit_encoder_if: producer/consumer handshake bundle for the EDAC encoder
interface edac_4bit_encoder_if;
  import edac_4bit_pkg::*;
  logic en;
  logic din_valid;
  logic din_ready;
  logic [DATA_W-1:0] DIN;
  logic [CRC_W-1:0] CRC;
  logic [CW_W-1:0] DOUT;
  logic dout_valid;
  logic dout_ready;
  logic busy;
  modport master (
    output en, din_valid, DIN, CRC, dout_ready,
    input din_ready, DOUT, dout_valid, busy
  );
  modport slave (
    input en, din_valid, DIN, CRC, dout_ready,
    output din_ready, DOUT, dout_valid, busy
  );
endinterface

// File: rtl/edac_4bit_encoder_lfsr.sv
// crc4_serial_lfsr: MSB-first serial CRC register with runtime polynomial (x^CRC_W implicit)
module crc4_serial_lfsr
  import edac_4bit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic step_i,
  input  logic bit_i,
  input  logic [CRC_W-1:0] poly_i,
  output logic [CRC_W-1:0] r_o
);
  logic [CRC_W-1:0] r_q;
  logic [CRC_W-1:0] r_d;
  logic fb;
  assign fb = r_q[CRC_W-1] ^ bit_i;
  assign r_d = {r_q[CRC_W-2:0], 1'b0} ^ (fb ? poly_i : '0);
  always_ff @(posedge clk) begin
    if (rst || clr_i) r_q <= '0;
    else if (step_i) r_q <= r_d;
  end
  assign r_o = r_q;
endmodule

// File: rtl/edac_4bit_encoder.sv
// edac_4bit_encoder: serial CRC encoder producing {4'h0, D, 4'h0, R} codewords
module edac_4bit_encoder
  import edac_4bit_pkg::*;
(
  input  logic CLK,
  input  logic reset,
  edac_4bit_encoder_if.slave bus
);
  enc_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] d_q;
  logic [CRC_W-1:0] poly_q;
  logic [CW_W-1:0] dout_q;
  logic dout_valid_q;
  logic [CRC_W-1:0] r;
  logic accept;
  logic last;
  assign bus.din_ready = bus.en && state_q == IDLE;
  assign accept = bus.din_ready && bus.din_valid;
  assign last = cnt_q == CNT_W'(DATA_W-1);
  crc4_serial_lfsr u_lfsr (
    .clk(CLK),
    .rst(reset),
    .clr_i(accept),
    .step_i(bus.en && state_q == SHIFT),
    .bit_i(d_q[CNT_W'(DATA_W-1) - cnt_q]),
    .poly_i(poly_q),
    .r_o(r)
  );
  // The codeword is registered one cycle after the final shift so r has settled.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      d_q <= '0;
      poly_q <= '0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
    end else if (bus.en) begin
      case (state_q)
        IDLE: if (bus.din_valid) begin
          state_q <= SHIFT;
          d_q <= bus.DIN;
          poly_q <= bus.CRC;
          cnt_q <= '0;
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) state_q <= DONE;
        end
        DONE: if (!dout_valid_q) begin
          dout_q <= pack_cw(d_q, r);
          dout_valid_q <= 1'b1;
        end else if (bus.dout_ready) begin
          state_q <= IDLE;
          dout_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.DOUT = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_edac_4bit_encoder.sv
// tb_edac_4bit_encoder: table-driven directed checks plus handshake/en/reset sequences
module tb_edac_4bit_encoder;
  logic CLK = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
  edac_4bit_encoder_if bus ();
  edac_4bit_encoder dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic [3:0] d;
    logic [3:0] c;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[19];
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic accept(input logic [3:0] d, input logic [3:0] c);
    int w = 0;
    while (!bus.din_ready && w < 20) begin
      tick();
      w++;
    end
    check("accept_ready", 16'(bus.din_ready), 16'h1);
    bus.DIN = d;
    bus.CRC = c;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.dout_valid && lat < 40);
  endtask
  task automatic take();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("take_clears_valid", 16'(bus.dout_valid), 16'h0);
  endtask
  initial begin
    int lat;
    logic [15:0] held;
    vecs[0] = '{4'h0, 4'h3, 16'h0000};
    vecs[1] = '{4'h1, 4'h3, 16'h0103};
    vecs[2] = '{4'h2, 4'h3, 16'h0206};
    vecs[3] = '{4'h3, 4'h3, 16'h0305};
    vecs[4] = '{4'h4, 4'h3, 16'h040C};
    vecs[5] = '{4'h5, 4'h3, 16'h050F};
    vecs[6] = '{4'h6, 4'h3, 16'h060A};
    vecs[7] = '{4'h7, 4'h3, 16'h0709};
    vecs[8] = '{4'h8, 4'h3, 16'h080B};
    vecs[9] = '{4'h9, 4'h3, 16'h0908};
    vecs[10] = '{4'hA, 4'h3, 16'h0A0D};
    vecs[11] = '{4'hB, 4'h3, 16'h0B0E};
    vecs[12] = '{4'hC, 4'h3, 16'h0C07};
    vecs[13] = '{4'hD, 4'h3, 16'h0D04};
    vecs[14] = '{4'hE, 4'h3, 16'h0E01};
    vecs[15] = '{4'hF, 4'h3, 16'h0F02};
    vecs[16] = '{4'hF, 4'h0, 16'h0F00};
    vecs[17] = '{4'h1, 4'h9, 16'h0109};
    vecs[18] = '{4'h5, 4'h9, 16'h0506};
    reset = 1'b1;
    bus.en = 1'b1;
    bus.din_valid = 1'b0;
    bus.DIN = '0;
    bus.CRC = '0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", bus.DOUT, 16'h0000);
    check("rst_valid", 16'(bus.dout_valid), 16'h0);
    check("rst_busy", 16'(bus.busy), 16'h0);
    reset = 1'b0;
    tick();
    check("idle_ready", 16'(bus.din_ready), 16'h1);
    for (int i = 0; i < 19; i++) begin
      accept(vecs[i].d, vecs[i].c);
      check("busy_after_accept", 16'(bus.busy), 16'h1);
      wait_valid(lat);
      check("latency", 16'(lat), 16'd5);
      check($sformatf("dout_d%h_p%h", vecs[i].d, vecs[i].c), bus.DOUT, vecs[i].exp);
      take();
      check("dout_holds", bus.DOUT, vecs[i].exp);
    end
    // back-pressure and input changes after accept
    accept(4'hB, 4'h3);
    bus.CRC = 4'hF;
    bus.DIN = 4'h0;
    wait_valid(lat);
    check("bp_latency", 16'(lat), 16'd5);
    held = bus.DOUT;
    check("bp_dout", held, 16'h0B0E);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stable_dout", bus.DOUT, 16'h0B0E);
      check("bp_stable_valid", 16'(bus.dout_valid), 16'h1);
      check("bp_no_ready", 16'(bus.din_ready), 16'h0);
    end
    // en low blocks the output handshake
    bus.en = 1'b0;
    bus.dout_ready = 1'b1;
    tick();
    tick();
    check("en_low_valid_held", 16'(bus.dout_valid), 16'h1);
    check("en_low_no_ready", 16'(bus.din_ready), 16'h0);
    bus.en = 1'b1;
    bus.dout_ready = 1'b0;
    take();
    // en low for 3 cycles mid-SHIFT stretches latency by 3
    accept(4'hB, 4'h3);
    tick();
    bus.en = 1'b0;
    tick();
    tick();
    tick();
    bus.en = 1'b1;
    lat = 4;
    do begin
      tick();
      lat++;
    end while (!bus.dout_valid && lat < 40);
    check("en_stretch_latency", 16'(lat), 16'd8);
    check("en_stretch_dout", bus.DOUT, 16'h0B0E);
    // no same-cycle turnaround from DONE
    bus.DIN = 4'h1;
    bus.CRC = 4'h3;
    bus.din_valid = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("turn_idle", 16'(bus.busy), 16'h0);
    check("turn_valid_low", 16'(bus.dout_valid), 16'h0);
    tick();
    bus.din_valid = 1'b0;
    check("turn_accept_next", 16'(bus.busy), 16'h1);
    wait_valid(lat);
    check("turn_latency", 16'(lat), 16'd5);
    check("turn_dout", bus.DOUT, 16'h0103);
    take();
    // reset mid-SHIFT aborts the word
    accept(4'hB, 4'h3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 16'(bus.dout_valid), 16'h0);
    check("mid_rst_dout", bus.DOUT, 16'h0000);
    check("mid_rst_busy", 16'(bus.busy), 16'h0);
    check("mid_rst_ready", 16'(bus.din_ready), 16'h1);
    tick();
    check("mid_rst_stays_idle", 16'(bus.busy), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
